// File: rtl/mdll_bb_pkg.sv
// Shared types and default constants for the MDLL bang-bang loop controller.
// Optional lock detector is enabled with `define MDLL_BB_LOCK_DET_EN.
package mdll_bb_pkg;

  typedef enum logic [1:0] {
    BB_IDLE   = 2'd0,
    BB_COARSE = 2'd1,
    BB_TRACK  = 2'd2,
    BB_LOCKED = 2'd3
  } bb_state_e;

  // Plain constants for the state register, kept bit-compatible with bb_state_e.
  localparam logic [1:0] ST_IDLE   = BB_IDLE;
  localparam logic [1:0] ST_COARSE = BB_COARSE;
  localparam logic [1:0] ST_TRACK  = BB_TRACK;
  localparam logic [1:0] ST_LOCKED = BB_LOCKED;

  localparam int N_CTL_DEF      = 8;
  localparam int N_ACC_DEF      = 6;
  localparam int ACC_TH_DEF     = 4;
  localparam int LOCK_CNT_DEF   = 16;
  localparam int UNLOCK_RUN_DEF = 4;

endpackage

// File: rtl/mdll_bb_lock_det.sv
// Lock / unlock detector for the MDLL bang-bang loop.
// Counts toggling decisions in TRACK and identical-decision runs in LOCKED.
// Only instantiated when MDLL_BB_LOCK_DET_EN is defined.
module mdll_bb_lock_det
  import mdll_bb_pkg::*;
#(
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int UNLOCK_RUN = UNLOCK_RUN_DEF
) (
  input  logic       clk_ref,
  input  logic       rst,
  input  logic       dec_valid,
  input  logic       dec_bit,
  input  logic [1:0] state,
  output logic       lock_set,
  output logic       lock_clr
);

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(UNLOCK_RUN + 1);

  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic          prev_bit_q, prev_bit_d;
  logic          prev_vld_q, prev_vld_d;
  logic          active, toggle;

  assign active = (state == ST_TRACK) || (state == ST_LOCKED);
  // The first decision after COARSE has no predecessor and never toggles.
  assign toggle = prev_vld_q && (dec_bit != prev_bit_q);

  // Next-state for counters and previous-decision register; pulse generation.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    run_cnt_d  = run_cnt_q;
    prev_bit_d = prev_bit_q;
    prev_vld_d = prev_vld_q;
    lock_set   = 1'b0;
    lock_clr   = 1'b0;
    if (!active) begin
      lock_cnt_d = '0;
      run_cnt_d  = '0;
      prev_vld_d = 1'b0;
    end else if (dec_valid) begin
      prev_bit_d = dec_bit;
      prev_vld_d = 1'b1;
      if (state == ST_TRACK) begin
        if (!toggle) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LW'(LOCK_CNT - 1)) begin
          lock_set   = 1'b1;
          lock_cnt_d = '0;
          // The locking decision starts a run of length one.
          run_cnt_d  = RW'(1);
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end else begin
        // Run counter holds the length of the current run of identical decisions.
        run_cnt_d = toggle ? RW'(1) : run_cnt_q + RW'(1);
        if (run_cnt_d == RW'(UNLOCK_RUN)) begin
          lock_clr   = 1'b1;
          run_cnt_d  = '0;
          lock_cnt_d = '0;
        end
      end
    end
  end

  // Counter and history registers.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      lock_cnt_q <= '0;
      run_cnt_q  <= '0;
      prev_bit_q <= 1'b0;
      prev_vld_q <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      run_cnt_q  <= run_cnt_d;
      prev_bit_q <= prev_bit_d;
      prev_vld_q <= prev_vld_d;
    end
  end

endmodule

// File: rtl/mdll_bb_ctrl.sv
// MDLL bang-bang loop controller: SAR coarse search of the DCO code followed by
// integral bang-bang tracking. Lock detection is present only when
// MDLL_BB_LOCK_DET_EN is defined; otherwise locked stays 0 and LOCKED is unused.
module mdll_bb_ctrl
  import mdll_bb_pkg::*;
#(
  parameter int N_CTL      = N_CTL_DEF,
  parameter int N_ACC      = N_ACC_DEF,
  parameter int ACC_TH     = ACC_TH_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int UNLOCK_RUN = UNLOCK_RUN_DEF
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             en,
  input  logic             bb_in,
  input  logic             bb_valid,
  output logic [N_CTL-1:0] ctl_code,
  output logic             locked,
  output logic [1:0]       state
);

  localparam int IDX_W = (N_CTL > 1) ? $clog2(N_CTL) : 1;
  localparam logic [N_CTL-1:0] MID = {1'b1, {(N_CTL-1){1'b0}}};

  logic [1:0]              state_q, state_d;
  logic [N_CTL-1:0]        code_q, code_d;
  logic signed [N_ACC-1:0] acc_q, acc_d, acc_sum;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    locked_q, locked_d;
  logic                    lock_set, lock_clr;

`ifdef MDLL_BB_LOCK_DET_EN
  logic dec_valid;
  assign dec_valid = bb_valid && en && (state_q != ST_IDLE);

  mdll_bb_lock_det #(
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_RUN(UNLOCK_RUN)
  ) u_lock_det (
    .clk_ref  (clk_ref),
    .rst      (rst),
    .dec_valid(dec_valid),
    .dec_bit  (bb_in),
    .state    (state_q),
    .lock_set (lock_set),
    .lock_clr (lock_clr)
  );
`else
  assign lock_set = 1'b0;
  assign lock_clr = 1'b0;
`endif

  // FSM, SAR search and tracking accumulator next-state.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    locked_d = locked_q;
    acc_sum  = bb_in ? acc_q + N_ACC'(1) : acc_q - N_ACC'(1);
    if (state_q == ST_IDLE) begin
      if (en) begin
        state_d = ST_COARSE;
        code_d  = MID;
        idx_d   = IDX_W'(N_CTL - 1);
      end
    end else if (!en) begin
      // Drop out of the loop but leave the DCO where it was.
      state_d  = ST_IDLE;
      locked_d = 1'b0;
      acc_d    = '0;
      idx_d    = IDX_W'(N_CTL - 1);
    end else if (bb_valid) begin
      if (state_q == ST_COARSE) begin
        if (!bb_in) code_d[idx_q] = 1'b0;
        if (idx_q != '0) begin
          code_d[idx_q - IDX_W'(1)] = 1'b1;
          idx_d = idx_q - IDX_W'(1);
        end else begin
          state_d = ST_TRACK;
          acc_d   = '0;
        end
      end else begin
        if (int'(acc_sum) >= ACC_TH) begin
          acc_d = '0;
          if (code_q != '1) code_d = code_q + N_CTL'(1);
        end else if (int'(acc_sum) <= -ACC_TH) begin
          acc_d = '0;
          if (code_q != '0) code_d = code_q - N_CTL'(1);
        end else begin
          acc_d = acc_sum;
        end
        if (state_q == ST_TRACK && lock_set) begin
          state_d  = ST_LOCKED;
          locked_d = 1'b1;
        end else if (state_q == ST_LOCKED && lock_clr) begin
          state_d  = ST_TRACK;
          locked_d = 1'b0;
        end
      end
    end
  end

  // Controller state registers.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      code_q   <= MID;
      acc_q    <= '0;
      idx_q    <= IDX_W'(N_CTL - 1);
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      locked_q <= locked_d;
    end
  end

  assign ctl_code = code_q;
  assign locked   = locked_q;
  assign state    = state_q;

endmodule
